// File: rtl/noc_traffic_gen_pkg.sv
// noc_traffic_gen_pkg: shared op codes, FSM states and data-field offsets (rev 1.0).
`default_nettype none
package noc_traffic_gen_pkg;

  localparam int CNT_W = 10;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_INIT = 3'd5;
  localparam logic [2:0] OP_FILL = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HEAD = 2'd1,
    ST_BODY = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int DEF_DEST_W = 10;
  localparam int DEF_VC_W   = 2;
  localparam int DEF_LEN_W  = 8;

  // Payload layout is {len, vc, dest} with dest in the LSBs.
  localparam int DEST_OFS = 0;
  localparam int VC_OFS   = DEF_DEST_W;
  localparam int LEN_OFS  = DEF_DEST_W + DEF_VC_W;

  function automatic int vc_ofs(input int dest_w);
    return dest_w;
  endfunction

  function automatic int len_ofs(input int dest_w, input int vc_w);
    return dest_w + vc_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/noc_traffic_table.sv
// noc_traffic_table: DEPTH-entry packet register file, one sync write, one comb read (rev 1.0).
`default_nettype none
module noc_traffic_table #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 20,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule
`default_nettype wire

// File: rtl/noc_traffic_gen.sv
// noc_traffic_gen: table-driven NoC packet/flit generator (rev 1.0).
// Optional macro NOC_TRAFFIC_GEN_STATS_EN adds the flits_sent counter output.
`default_nettype none
module noc_traffic_gen
  import noc_traffic_gen_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int DEST_W = DEF_DEST_W,
  parameter int VC_W   = DEF_VC_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [2:0]                   op,
  input  logic [DEST_W+VC_W+LEN_W-1:0] data,
  output logic                         flit_valid,
  input  logic                         flit_ready,
  output logic                         flit_head,
  output logic                         flit_tail,
  output logic [DEST_W-1:0]            flit_dst,
  output logic [VC_W-1:0]              flit_vc,
  output logic                         done,
`ifdef NOC_TRAFFIC_GEN_STATS_EN
  output logic [15:0]                  flits_sent,
`endif
  output logic                         fill_err
);

  localparam int DATA_W  = DEST_W + VC_W + LEN_W;
  localparam int AW      = $clog2(DEPTH);
  localparam int VC_LSB  = vc_ofs(DEST_W);
  localparam int LEN_LSB = len_ofs(DEST_W, VC_W);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t             state, state_n;
  logic [CNT_W-1:0]   count, count_n, head, head_n, sent, sent_n, total, total_n;
  logic [CNT_W-1:0]   head_inc, sent_inc;
  logic [LEN_W-1:0]   remaining, remaining_n, e_len;
  logic [DATA_W-1:0]  entry;
  logic               fill_err_n, we, xfer, tail_xfer;

  noc_traffic_table #(.DEPTH(DEPTH), .WIDTH(DATA_W)) u_table (
    .clk   (clk),
    .we    (we),
    .waddr (count[AW-1:0]),
    .wdata (data),
    .raddr (head[AW-1:0]),
    .rdata (entry)
  );

  assign e_len      = entry[LEN_LSB +: LEN_W];
  assign flit_valid = (state == ST_HEAD) || (state == ST_BODY);
  assign flit_head  = (state == ST_HEAD);
  assign flit_tail  = ((state == ST_HEAD) && (e_len <= LEN_W'(1))) ||
                      ((state == ST_BODY) && (remaining == LEN_W'(1)));
  assign flit_dst   = flit_valid ? entry[DEST_W-1:0] : '0;
  assign flit_vc    = flit_valid ? entry[VC_LSB +: VC_W] : '0;
  assign done       = (sent >= total);
  assign xfer       = flit_valid && flit_ready;
  assign tail_xfer  = xfer && flit_tail;
  assign head_inc   = head + 1'b1;
  assign sent_inc   = sent + 1'b1;

  always_comb begin
    state_n     = state;
    count_n     = count;
    head_n      = head;
    sent_n      = sent;
    total_n     = total;
    remaining_n = remaining;
    fill_err_n  = fill_err;
    we          = 1'b0;
    if (op == OP_INIT) begin
      // INIT wins over any in-flight packet: it is dropped with no tail.
      count_n     = '0;
      head_n      = '0;
      sent_n      = '0;
      fill_err_n  = 1'b0;
      remaining_n = '0;
      total_n     = data[CNT_W-1:0];
      state_n     = (data[CNT_W-1:0] == '0) ? ST_DONE : ST_IDLE;
    end else begin
      if (op == OP_FILL) begin
        if (count == DEPTH_C) begin
          fill_err_n = 1'b1;
        end else begin
          we      = 1'b1;
          count_n = count + 1'b1;
        end
      end
      case (state)
        ST_IDLE: if (count != '0 && total > sent) state_n = ST_HEAD;
        ST_HEAD: if (xfer && !flit_tail) begin
          remaining_n = e_len - 1'b1;
          state_n     = ST_BODY;
        end
        ST_BODY: if (xfer && !flit_tail) remaining_n = remaining - 1'b1;
        ST_DONE: state_n = ST_DONE;
        default: state_n = ST_IDLE;
      endcase
      if (tail_xfer) begin
        sent_n  = (sent == CNT_MAX) ? sent : sent_inc;
        head_n  = (head_inc == count) ? '0 : head_inc;
        state_n = (sent_inc == total) ? ST_DONE : ST_HEAD;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      count     <= '0;
      head      <= '0;
      sent      <= '0;
      total     <= '0;
      remaining <= '0;
      fill_err  <= 1'b0;
    end else begin
      state     <= state_n;
      count     <= count_n;
      head      <= head_n;
      sent      <= sent_n;
      total     <= total_n;
      remaining <= remaining_n;
      fill_err  <= fill_err_n;
    end
  end

`ifdef NOC_TRAFFIC_GEN_STATS_EN
  always_ff @(posedge clk) begin
    if (rst || op == OP_INIT) flits_sent <= '0;
    else if (xfer && flits_sent != 16'hFFFF) flits_sent <= flits_sent + 1'b1;
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_noc_traffic_gen.sv
// tb_noc_traffic_gen: randomized and directed checks against a packet-stream reference model.
`default_nettype none
module tb_noc_traffic_gen;
  import noc_traffic_gen_pkg::*;

  localparam int DEPTH = 16, DEST_W = 10, VC_W = 2, LEN_W = 8;
  localparam int DW = DEST_W + VC_W + LEN_W;

  logic              clk = 1'b0;
  logic              rst, flit_ready;
  logic [2:0]        op;
  logic [DW-1:0]     data;
  logic              flit_valid, flit_head, flit_tail, done, fill_err;
  logic [DEST_W-1:0] flit_dst;
  logic [VC_W-1:0]   flit_vc;
`ifdef NOC_TRAFFIC_GEN_STATS_EN
  logic [15:0]       flits_sent;
`endif

  noc_traffic_gen #(.DEPTH(DEPTH), .DEST_W(DEST_W), .VC_W(VC_W), .LEN_W(LEN_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .op         (op),
    .data       (data),
    .flit_valid (flit_valid),
    .flit_ready (flit_ready),
    .flit_head  (flit_head),
    .flit_tail  (flit_tail),
    .flit_dst   (flit_dst),
    .flit_vc    (flit_vc),
    .done       (done),
`ifdef NOC_TRAFFIC_GEN_STATS_EN
    .flits_sent (flits_sent),
`endif
    .fill_err   (fill_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [LEN_W-1:0]  len;
    logic [VC_W-1:0]   vc;
    logic [DEST_W-1:0] dest;
  } ent_t;

  typedef struct packed {
    logic              h;
    logic              t;
    logic [DEST_W-1:0] d;
    logic [VC_W-1:0]   v;
  } flit_t;

  ent_t  tab [DEPTH];
  int    m_count, m_total;
  logic  m_err;
  flit_t expq[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_init(input int tot);
    op   = OP_INIT;
    data = DW'(tot);
    step();
    op = OP_NOP;
    m_count = 0;
    m_total = tot;
    m_err   = 1'b0;
  endtask

  task automatic do_fill(input int len, input int vc, input int dest);
    ent_t e;
    e.len  = LEN_W'(len);
    e.vc   = VC_W'(vc);
    e.dest = DEST_W'(dest);
    op   = OP_FILL;
    data = e;
    step();
    op = OP_NOP;
    if (m_count < DEPTH) begin
      tab[m_count] = e;
      m_count++;
    end else begin
      m_err = 1'b1;
    end
  endtask

  // pct < 0 toggles ready 1,0,1,0...; otherwise ready is high pct% of cycles.
  task automatic run(input int pct, input int budget);
    int    idx, cyc, bubbles;
    bit    started, stalled;
    flit_t held, fl;
    expq.delete();
    for (int p = 0; p < m_total; p++) begin
      ent_t e;
      int   n;
      e = tab[p % m_count];
      n = (e.len <= 1) ? 1 : int'(e.len);
      for (int f = 0; f < n; f++) begin
        fl.h = (f == 0);
        fl.t = (f == n - 1);
        fl.d = e.dest;
        fl.v = e.vc;
        expq.push_back(fl);
      end
    end
    idx = 0; cyc = 0; bubbles = 0; started = 0; stalled = 0; held = '0;
    check("done_at_start", {31'd0, done}, {31'd0, (m_total == 0)});
    while (idx < expq.size() && cyc < budget) begin
      flit_ready = (pct < 0) ? (cyc % 2 == 0) : ($urandom_range(99) < pct);
      #1;
      if (stalled)
        check("stable", {17'd0, flit_valid, flit_head, flit_tail, flit_dst, flit_vc}, {17'd0, 1'b1, held});
      if (flit_valid) started = 1;
      else if (started) bubbles++;
      if (flit_valid && flit_ready) begin
        check($sformatf("flit%0d", idx), {18'd0, flit_head, flit_tail, flit_dst, flit_vc}, {18'd0, expq[idx]});
        idx++;
        stalled = 0;
      end else if (flit_valid) begin
        stalled = 1;
        held    = {flit_head, flit_tail, flit_dst, flit_vc};
      end else begin
        stalled = 0;
      end
      step();
      cyc++;
    end
    flit_ready = 1'b0;
    check("flit_count", idx, expq.size());
    if (pct == 100) check("bubbles", bubbles, 0);
    check("done_at_end", {31'd0, done}, 32'd1);
    check("idle_at_end", {31'd0, flit_valid}, 32'd0);
`ifdef NOC_TRAFFIC_GEN_STATS_EN
    check("flits_sent", {16'd0, flits_sent}, expq.size());
`endif
  endtask

  initial begin
    int n, waitc;
    rst = 1'b1; op = OP_NOP; data = '0; flit_ready = 1'b0;
    step(); step();
    check("rst_valid", {31'd0, flit_valid}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd1);
    check("rst_fill_err", {31'd0, fill_err}, 32'd0);
    check("rst_route", {18'd0, flit_head, flit_tail, flit_dst, flit_vc}, 32'd0);
    rst = 1'b0;

    // single-flit packets, ready always high
    do_init(3); do_fill(1, 2, 5); run(100, 50);

    // four-flit packet with ready toggling
    do_init(1); do_fill(4, 1, 9); run(-1, 60);

    // two-entry round robin
    do_init(5); do_fill(2, 0, 1); do_fill(2, 3, 2); run(100, 100);

    // table overflow: 17th FILL dropped, entry 0 intact, wrap at 16
    do_init(17);
    for (int i = 0; i < 17; i++) do_fill(0, i % 4, 100 + i);
    check("fill_err_set", {31'd0, fill_err}, {31'd0, m_err});
    run(100, 100);
    do_init(0);
    check("fill_err_clr", {31'd0, fill_err}, 32'd0);

    // total==0: never valid
    check("zero_done", {31'd0, done}, 32'd1);
    do_fill(1, 0, 3);
    for (int i = 0; i < 5; i++) begin
      check("zero_valid", {31'd0, flit_valid}, 32'd0);
      step();
    end

    // INIT in the middle of a body
    do_init(1); do_fill(5, 1, 7);
    flit_ready = 1'b1;
    waitc = 0;
    while (!flit_valid && waitc < 20) begin step(); waitc++; end
    check("mid_wait", {31'd0, flit_valid}, 32'd1);
    step(); step();
    check("mid_in_body", {29'd0, flit_valid, flit_head, flit_tail}, 32'b100);
    flit_ready = 1'b0;
    op = OP_INIT; data = DW'(2);
    step();
    op = OP_NOP;
    check("abort_valid", {31'd0, flit_valid}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      check("abort_quiet", {31'd0, flit_valid}, 32'd0);
      step();
    end

    // randomized tables and backpressure
    for (int it = 0; it < 10; it++) begin
      do_init($urandom_range(12, 1));
      n = $urandom_range(6, 1);
      for (int j = 0; j < n; j++)
        do_fill($urandom_range(5, 0), $urandom_range(3, 0), $urandom_range(1023, 0));
      run($urandom_range(90, 40), 2000);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
